// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared memory-command and fetch/mem unit state types.
package cpu_mem_pkg;
  typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10} mem_cmd_t;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} fsu_state_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: sequential PC and branch-target computation, wrapping modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int ADDR_W = 9,
  parameter int OFF_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  off,
  input  logic [ADDR_W-1:0] target,
  input  logic              abs,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] pc_br
);
  logic [ADDR_W-1:0] sext;
  assign sext = ADDR_W'($signed(off));
  assign pc_inc = pc + ADDR_W'(1);
  assign pc_br = abs ? target : pc + sext;
endmodule

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: instruction fetch / data access unit with variable-latency memory handshake.
// MEM_TIMEOUT_EN aborts accesses stalled for TIMEOUT_CYC cycles and raises sticky err.
module fetch_mem_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int OFF_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              branch_en,
  input  logic              branch_abs,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_cmd,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link,
  output logic              busy,
  output logic              fetch_done,
  output logic              data_done,
  output logic              err
);
  fsu_state_t state;
  logic [ADDR_W-1:0] daddr, pc_inc, pc_br;
  logic dwr, timeout;
  pc_next_calc #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_pc_next (
    .pc(pc), .off(branch_off), .target(branch_target), .abs(branch_abs),
    .pc_inc(pc_inc), .pc_br(pc_br)
  );
  assign busy = state != IDLE;
  assign mem_addr = state == DATA ? daddr : pc;
  assign mem_cmd = state == IDLE ? MEM_NONE : (state == DATA && dwr) ? MEM_WRITE : MEM_READ;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      data_rdata <= '0;
      link <= '0;
      write_data <= '0;
      daddr <= '0;
      dwr <= 1'b0;
      fetch_done <= 1'b0;
      data_done <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        IDLE:
          if (branch_en) begin
            link <= pc;
            pc <= pc_br;
          end else if (data_req) begin
            daddr <= data_addr;
            write_data <= data_wdata;
            dwr <= data_wr;
            state <= DATA;
          end else if (fetch_req) state <= FETCH;
        FETCH:
          if (mem_ready) begin
            ir <= read_data;
            pc <= pc_inc;
            fetch_done <= 1'b1;
            state <= IDLE;
          end else if (timeout) state <= IDLE;
        DATA:
          if (mem_ready) begin
            if (!dwr) data_rdata <= read_data;
            data_done <= 1'b1;
            state <= IDLE;
          end else if (timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt;
  // cnt is zero in IDLE, so it counts from zero on every entry to FETCH/DATA
  assign timeout = busy && !mem_ready && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= busy ? cnt + CW'(1) : '0;
      if (timeout) err <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: randomized scoreboard bench with a memory model and architectural PC model.
module tb_fetch_mem_unit;
  logic clk = 0, reset = 1, fetch_req = 0, data_req = 0, data_wr = 0;
  logic branch_en = 0, branch_abs = 0, mem_ready = 0;
  logic [8:0] data_addr = 0, branch_target = 0;
  logic [15:0] data_wdata = 0, read_data = 0;
  logic [7:0] branch_off = 0;
  logic [8:0] mem_addr, pc, link;
  logic [1:0] mem_cmd;
  logic [15:0] write_data, ir, data_rdata;
  logic busy, fetch_done, data_done, err;
  int checks = 0, errors = 0;
  logic [15:0] mem [512];
  logic [8:0] pc_m = 0, link_m = 0;
  logic [15:0] ir_m = 0, dr_m = 0;
  typedef struct {bit is_fetch; logic [15:0] val; logic [8:0] pc;} exp_t;
  exp_t q[$];
  exp_t e;

  fetch_mem_unit dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req), .data_wr(data_wr),
    .data_addr(data_addr), .data_wdata(data_wdata), .branch_en(branch_en), .branch_abs(branch_abs),
    .branch_off(branch_off), .branch_target(branch_target), .mem_ready(mem_ready),
    .read_data(read_data), .mem_addr(mem_addr), .mem_cmd(mem_cmd), .write_data(write_data),
    .ir(ir), .data_rdata(data_rdata), .pc(pc), .link(link), .busy(busy),
    .fetch_done(fetch_done), .data_done(data_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic clear();
    fetch_req = 0; data_req = 0; branch_en = 0; mem_ready = 0;
  endtask

  // requests while busy must be ignored; read_data garbage must not be latched
  task automatic noise();
    fetch_req = 1'($urandom); data_req = 1'($urandom); branch_en = 1'($urandom);
    data_addr = 9'($urandom); data_wdata = 16'($urandom); read_data = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input int waits);
    logic [8:0] a;
    a = pc_m;
    clear(); fetch_req = 1;
    step(); clear();
    ir_m = mem[a]; pc_m = a + 9'd1;
    q.push_back('{1'b1, ir_m, pc_m});
    repeat (waits) begin
      chk("fetch_cmd", mem_cmd, 1); chk("fetch_addr", mem_addr, a);
      chk("fetch_busy", busy, 1); chk("fetch_pc_hold", pc, a);
      noise(); step(); clear();
    end
    chk("fetch_cmd", mem_cmd, 1); chk("fetch_addr", mem_addr, a);
    noise(); mem_ready = 1; read_data = mem[a];
    step(); clear();
    chk("fetch_end_busy", busy, 0);
  endtask

  task automatic do_data(input bit wr, input logic [8:0] addr, input logic [15:0] wd, input int waits);
    clear(); data_req = 1; data_wr = wr; data_addr = addr; data_wdata = wd;
    step(); clear();
    data_wr = 1'($urandom);
    if (wr) mem[addr] = wd; else dr_m = mem[addr];
    q.push_back('{1'b0, dr_m, pc_m});
    repeat (waits) begin
      chk("data_cmd", mem_cmd, wr ? 2 : 1); chk("data_addr", mem_addr, addr);
      chk("data_busy", busy, 1);
      if (wr) chk("data_wdata", write_data, wd);
      noise(); step(); clear();
    end
    chk("data_cmd", mem_cmd, wr ? 2 : 1); chk("data_addr", mem_addr, addr);
    if (wr) chk("data_wdata", write_data, wd);
    noise(); mem_ready = 1; read_data = wr ? 16'($urandom) : mem[addr];
    step(); clear();
    chk("data_end_busy", busy, 0);
  endtask

  // branch always competes with fetch and data requests, which must lose
  task automatic do_branch(input bit abs, input logic [7:0] off, input logic [8:0] tgt);
    int soff;
    logic [8:0] want;
    soff = off[7] ? int'(off) - 256 : int'(off);
    want = abs ? tgt : 9'((int'(pc_m) + soff + 512) % 512);
    clear(); branch_en = 1; branch_abs = abs; branch_off = off; branch_target = tgt;
    fetch_req = 1; data_req = 1; data_wr = 1'($urandom); mem_ready = 1'($urandom);
    step(); clear();
    link_m = pc_m; pc_m = want;
    chk("br_pc", pc, pc_m); chk("br_link", link, link_m);
    chk("br_busy", busy, 0); chk("br_cmd", mem_cmd, 0); chk("br_addr", mem_addr, pc_m);
  endtask

  always @(negedge clk)
    if (!reset && (fetch_done || data_done)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got fetch_done=%0b data_done=%0b expected no pulse", fetch_done, data_done);
      end else begin
        e = q.pop_front();
        chk("done_kind", {30'd0, fetch_done, data_done}, e.is_fetch ? 2 : 1);
        chk("done_pc", pc, e.pc);
        if (e.is_fetch) chk("done_ir", ir, e.val); else chk("done_rdata", data_rdata, e.val);
      end
    end

  initial begin
    logic [8:0] a;
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[0] = 16'hD105;
    step(); step();
    chk("rst_pc", pc, 0); chk("rst_ir", ir, 0); chk("rst_link", link, 0);
    chk("rst_rdata", data_rdata, 0); chk("rst_wdata", write_data, 0);
    chk("rst_cmd", mem_cmd, 0); chk("rst_addr", mem_addr, 0); chk("rst_busy", busy, 0);
    chk("rst_done", {fetch_done, data_done}, 0); chk("rst_err", err, 0);
    reset = 0;
    step();
    do_fetch(0);
    chk("first_ir", ir, 16'hD105); chk("first_pc", pc, 1);
    do_fetch(3);
    do_data(1, 9'h140, 16'hBEEF, 2);
    do_data(0, 9'h140, 16'h0, 1);
    do_data(0, 9'h140, 16'h0, 0);
    do_branch(1, 8'h00, 9'h1FF);
    do_fetch(1);
    chk("wrap_pc", pc, 0);
    do_branch(1, 8'h00, 9'h005);
    do_branch(0, 8'hFE, 9'h000);
    chk("rel_pc", pc, 3); chk("rel_link", link, 5);
    do_branch(1, 8'h00, 9'h0A0);
    chk("abs_pc", pc, 9'h0A0);
    repeat (300) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) do_fetch($urandom_range(0, 4));
      else if (op < 8) do_data(1'($urandom), 9'($urandom), 16'($urandom), $urandom_range(0, 4));
      else do_branch(1'($urandom), 8'($urandom), 9'($urandom));
      if ($urandom_range(0, 3) == 0) begin noise(); branch_en = 0; fetch_req = 0; data_req = 0; mem_ready = 1; step(); clear(); end
    end
    step(); step();
    chk("queue_drained", q.size(), 0);
    clear(); fetch_req = 1;
    step(); clear();
    chk("mid_cmd", mem_cmd, 1);
    #2 reset = 1;
    #1 chk("mid_rst_cmd", mem_cmd, 0); chk("mid_rst_pc", pc, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 0);
    step(); reset = 0;
    pc_m = 0; link_m = 0; ir_m = 0; dr_m = 0;
    step();
    do_fetch(2);
`ifdef MEM_TIMEOUT_EN
    a = pc_m;
    clear(); fetch_req = 1;
    step(); clear();
    repeat (16) begin chk("to_busy", busy, 1); step(); end
    chk("to_idle", busy, 0); chk("to_err", err, 1); chk("to_pc", pc, a); chk("to_ir", ir, ir_m);
    do_fetch(1);
    chk("to_err_sticky", err, 1);
`else
    a = pc_m;
    chk("err_tied", err, 0);
    chk("pc_final", pc, a);
`endif
    step(); step();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
